rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Shares one synchronous-read ROM (1-cycle registered read, `WIDTH` × `DEPTH`) between two requesters. It runs a round-robin arbiter and a small read sequencer: it accepts one request, drives the ROM address, captures the returned word, and hands it back with a one-cycle valid pulse to the requester that won. It sits between the ROM instance and two client blocks, for example a display sequencer and a coefficient loader, so neither client drives the ROM address directly.

## Interface
- `WIDTH`, 8, data word width; must match the ROM.
- `DEPTH`, 16, ROM word count; must match the ROM.
- `DEPTH_LOG`, `$clog2(DEPTH)`, address width.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_0`  in  1  requester 0 read request; level, held until `gnt_0`.
- `addr_0`  in  `DEPTH_LOG`  requester 0 address; held stable while `req_0` is high.
- `gnt_0`  out  1  one-cycle pulse: request 0 accepted and `addr_0` sampled.
- `valid_0`  out  1  one-cycle pulse: `data_out` holds requester 0's word.
- `req_1`, `addr_1`, `gnt_1`, `valid_1`: same as above, for requester 1.
- `rom_addr`  out  `DEPTH_LOG`  registered address to the ROM's `addr_rd`.
- `rom_data`  in  `WIDTH`  ROM `data_out`.
- `data_out`  out  `WIDTH`  registered read result; holds its value until the next capture.
- `busy`  out  1  high while a transaction is in flight (state ≠ IDLE).

## Operation
- FSM has three states: IDLE → ADDR → CAPT → IDLE. It is not pipelined, so at most one transaction is in flight.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner:
    - Only one `req_x` high: that requester wins.
    - Both high: the requester that is not `last` wins.
  - On the winning edge:
    - `rom_addr` <= `addr_winner`
    - `gnt_winner` <= 1
    - `owner` <= winner
    - `last` <= winner
    - state <= ADDR
- ADDR: the ROM samples `rom_addr` on this edge; `gnt_x` <= 0; state <= CAPT.
- CAPT:
  - `data_out` <= `rom_data`
  - `valid_owner` <= 1
  - state <= IDLE
- All `gnt_x` and `valid_x` are single-cycle pulses. Both `gnt_x` are never high together, and both `valid_x` are never high together.
- A requester that wants back-to-back reads keeps `req_x` high after `gnt_x`. That counts as a new request, arbitrated in IDLE.
- If `req_x` drops before its grant, the request is abandoned and no state changes.
- Round-robin guarantees that under continuous contention grants alternate 0,1,0,1…
- Changing `addr_x` after `gnt_x` has no effect on the transaction already accepted.
- `rom_addr` holds its last value outside transactions.

## Timing
- Edge numbering for one transaction:
  - E0: request seen in IDLE. `gnt_x` is high during E0–E1.
  - E1: ROM registers the word.
  - E2: `data_out` and `valid_x` are updated. `valid_x` is high during E2–E3.
- Latency from the first edge with `req_x` high (arbiter idle) to `valid_x` high is 3 edges.
- The next grant can occur at E3, giving a throughput of 1 read per 3 cycles.
- `busy` is high from after E0 until after E2.
- Reset values:
  - `rom_addr` = 0, `data_out` = 0
  - `gnt_0` = `gnt_1` = 0
  - `valid_0` = `valid_1` = 0
  - `busy` = 0
  - state = IDLE
  - `last` = 1, so requester 0 wins the first contention.
- Reset asserted mid-transaction takes effect on the next edge: the transaction is aborted, no `valid_x` is issued, and the pulses clear. Requesters must re-request after reset deasserts.
- Reset has priority over every request.

## Test plan
ROM is preloaded so that rom[i] = 8'hA0 + i.
- Single read: `req_0`=1, `addr_0`=5 at E0 → `gnt_0` pulse after E0, `rom_addr`=5, `valid_0` pulse after E2 with `data_out`=8'hA5; `valid_1` stays 0.
- Contention after reset: both requests high at E0, `addr_0`=2, `addr_1`=9 → requester 0 served first (`data_out`=8'hA2, `valid_0`), then requester 1 granted at E3 (`data_out`=8'hA9, `valid_1` after E5).
- Fairness: both requests held high for 12 cycles → grant order 0,1,0,1; exactly 4 grants; `valid` pulses alternate; data matches each address.
- Sweep: requester 1 alone reads addresses 0..15 back-to-back, holding `req_1` high and changing `addr_1` after each `gnt_1` → 16 `valid_1` pulses with data A0..AF, spaced 3 cycles apart; wrap to address 0 returns 8'hA0.
- Abandoned request: `req_0` high for 1 cycle while a requester-1 transaction is busy, dropped before IDLE → no `gnt_0`, no `valid_0`.
- Reset mid-op: assert `reset` at the ADDR edge of a read to address 7 → no `valid` pulse; all outputs read their reset values the cycle after; after release a new `req_1` to address 7 returns 8'hA7.

Source files
------------

// File: rtl/rom_arbiter.sv
// Round-robin front end that lets two requesters share one synchronous-read ROM.
// Each accepted request runs IDLE -> ADDR -> CAPT and returns one word with a valid pulse.
module rom_arbiter #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_0,
    input  logic [DEPTH_LOG-1:0] addr_0,
    output logic                 gnt_0,
    output logic                 valid_0,
    input  logic                 req_1,
    input  logic [DEPTH_LOG-1:0] addr_1,
    output logic                 gnt_1,
    output logic                 valid_1,
    output logic [DEPTH_LOG-1:0] rom_addr,
    input  logic [WIDTH-1:0]     rom_data,
    output logic [WIDTH-1:0]     data_out,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ADDR, CAPT} state_t;

    state_t state;
    state_t state_next;
    logic   any_req;
    logic   winner;
    logic   grant;
    logic   capture;
    logic   last;
    logic   owner;

    // Under contention the requester that was not served last wins.
    assign any_req = req_0 | req_1;
    assign winner  = (req_0 & req_1) ? ~last : req_1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; combinational blocks use blocking ones.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ADDR;
            ADDR:    state_next = CAPT;
            CAPT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        grant   = (state == IDLE) && any_req;
        capture = (state == CAPT);
    end

    // Pulses are recomputed every edge, so they fall after one cycle by construction.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr <= '0;
            data_out <= '0;
            gnt_0    <= 1'b0;
            gnt_1    <= 1'b0;
            valid_0  <= 1'b0;
            valid_1  <= 1'b0;
            owner    <= 1'b0;
            last     <= 1'b1;
        end else begin
            gnt_0   <= grant & ~winner;
            gnt_1   <= grant & winner;
            valid_0 <= capture & ~owner;
            valid_1 <= capture & owner;
            if (grant) begin
                rom_addr <= winner ? addr_1 : addr_0;
                owner    <= winner;
                last     <= winner;
            end
            if (capture) data_out <= rom_data;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a ROM model, a transaction-level reference scheduler,
// directed scenarios with literal expectations, and a randomized soak.
module tb_rom_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int DL    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_0 = 1'b0;
    logic             req_1 = 1'b0;
    logic [DL-1:0]    addr_0 = '0;
    logic [DL-1:0]    addr_1 = '0;
    logic             gnt_0, gnt_1, valid_0, valid_1, busy;
    logic [DL-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic [WIDTH-1:0] data_out;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    rom_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .addr_0(addr_0), .gnt_0(gnt_0), .valid_0(valid_0),
        .req_1(req_1), .addr_1(addr_1), .gnt_1(gnt_1), .valid_1(valid_1),
        .rom_addr(rom_addr), .rom_data(rom_data), .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM preloaded with A0 + index.
    logic [WIDTH-1:0] rom [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) rom[i] = WIDTH'(8'hA0 + i);
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a grant at edge n delivers A0+addr at edge n+2; the arbiter is free from n+3.
    typedef struct {
        int         cyc;
        bit         port;
        logic [7:0] data;
    } pend_t;

    pend_t      pend[$];
    bit         glog[$];
    int         cyc = 0;
    int         free_at = 0;
    bit         last_m = 1'b1;
    bit         m_gnt0, m_gnt1, m_valid0, m_valid1, m_busy;
    logic [3:0] m_rom_addr = '0;
    logic [7:0] m_data = '0;

    always @(posedge clk) begin : model
        pend_t      p;
        bit         w;
        logic [3:0] a;
        m_gnt0 = 0; m_gnt1 = 0; m_valid0 = 0; m_valid1 = 0;
        if (reset) begin
            pend.delete();
            free_at    = cyc + 1;
            last_m     = 1'b1;
            m_rom_addr = '0;
            m_data     = '0;
            m_busy     = 1'b0;
        end else begin
            if (pend.size() > 0 && pend[0].cyc == cyc) begin
                p = pend.pop_front();
                if (p.port) m_valid1 = 1'b1;
                else        m_valid0 = 1'b1;
                m_data = p.data;
            end
            if (cyc >= free_at && (req_0 || req_1)) begin
                w = (req_0 && req_1) ? !last_m : req_1;
                a = w ? addr_1 : addr_0;
                if (w) m_gnt1 = 1'b1;
                else   m_gnt0 = 1'b1;
                m_rom_addr = a;
                p.cyc  = cyc + 2;
                p.port = w;
                p.data = 8'hA0 + {4'h0, a};
                pend.push_back(p);
                free_at = cyc + 3;
                last_m  = w;
                glog.push_back(w);
            end
            m_busy = (cyc + 1 < free_at);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("gnt_0",    32'(gnt_0),    32'(m_gnt0));
            check("gnt_1",    32'(gnt_1),    32'(m_gnt1));
            check("valid_0",  32'(valid_0),  32'(m_valid0));
            check("valid_1",  32'(valid_1),  32'(m_valid1));
            check("busy",     32'(busy),     32'(m_busy));
            check("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
            check("data_out", 32'(data_out), 32'(m_data));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests %0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        int         base, ngnt, cnt;
        bit         fo[$];
        logic [7:0] vals[$];

        repeat (2) @(posedge clk);
        #1 cmp_en = 1'b1;
        tick();
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_gnt",      32'({gnt_1, gnt_0}), 32'h0);
        reset = 1'b0;

        // Single read of address 5
        req_0 = 1'b1; addr_0 = 4'd5;
        tick();
        check("single_gnt_0", 32'(gnt_0), 32'h1);
        check("single_rom_addr", 32'(rom_addr), 32'h5);
        req_0 = 1'b0;
        tick(); tick();
        check("single_valid_0", 32'(valid_0), 32'h1);
        check("single_data", 32'(data_out), 32'hA5);
        check("single_valid_1", 32'(valid_1), 32'h0);
        tick();
        check("single_valid_0_fall", 32'(valid_0), 32'h0);

        // Contention right after reset: requester 0 first, then 1 at E3
        do_reset();
        req_0 = 1'b1; req_1 = 1'b1; addr_0 = 4'd2; addr_1 = 4'd9;
        tick();
        check("cont_gnt_0", 32'(gnt_0), 32'h1);
        check("cont_gnt_1_low", 32'(gnt_1), 32'h0);
        req_0 = 1'b0;
        tick(); tick();
        check("cont_data_0", 32'(data_out), 32'hA2);
        tick();
        check("cont_gnt_1", 32'(gnt_1), 32'h1);
        req_1 = 1'b0;
        tick(); tick();
        check("cont_valid_1", 32'(valid_1), 32'h1);
        check("cont_data_1", 32'(data_out), 32'hA9);
        tick();

        // Fairness: both held for 12 edges
        base = glog.size(); ngnt = 0;
        req_0 = 1'b1; req_1 = 1'b1; addr_0 = 4'd4; addr_1 = 4'd11;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (gnt_0 || gnt_1) begin
                ngnt++;
                fo.push_back(gnt_1);
            end
        end
        req_0 = 1'b0; req_1 = 1'b0;
        check("fair_count", 32'(ngnt), 32'd4);
        check("fair_model_count", 32'(glog.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("fair_model_order", 32'(glog[base + k]), 32'(k % 2));
            check("fair_dut_order", 32'(fo[k]), 32'(k % 2));
        end
        tick(); tick();

        // Sweep: requester 1 alone, addresses 0..15 then wrap to 0
        ngnt = 0;
        addr_1 = 4'd0; req_1 = 1'b1;
        for (int k = 0; k < 54; k++) begin
            tick();
            if (valid_1) vals.push_back(data_out);
            if (gnt_1) begin
                ngnt++;
                if (ngnt == 17) req_1 = 1'b0;
                else            addr_1 = addr_1 + 4'd1;
            end
        end
        check("sweep_grants", 32'(ngnt), 32'd17);
        check("sweep_valids", 32'(vals.size()), 32'd17);
        check("sweep_first", 32'(vals[0]), 32'hA0);
        check("sweep_last15", 32'(vals[15]), 32'hAF);
        check("sweep_wrap", 32'(vals[16]), 32'hA0);

        // Abandoned request from requester 0 while 1 is busy
        req_1 = 1'b1; addr_1 = 4'd3;
        tick();
        req_1 = 1'b0; req_0 = 1'b1; addr_0 = 4'd6;
        tick();
        req_0 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (gnt_0 || valid_0) cnt++;
        end
        check("abandon_no_req0_activity", 32'(cnt), 32'd0);

        // Reset at the ADDR edge of a read to address 7
        req_1 = 1'b1; addr_1 = 4'd7;
        tick();
        check("midrst_gnt_1", 32'(gnt_1), 32'h1);
        req_1 = 1'b0; reset = 1'b1;
        tick();
        check("midrst_outputs", 32'({gnt_0, gnt_1, valid_0, valid_1, busy}), 32'h0);
        check("midrst_rom_addr", 32'(rom_addr), 32'h0);
        check("midrst_data_out", 32'(data_out), 32'h0);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (valid_0 || valid_1) cnt++;
        end
        check("midrst_no_valid", 32'(cnt), 32'd0);
        req_1 = 1'b1; addr_1 = 4'd7;
        tick();
        req_1 = 1'b0;
        tick(); tick();
        check("midrst_retry_valid", 32'(valid_1), 32'h1);
        check("midrst_retry_data", 32'(data_out), 32'hA7);
        tick();

        // Randomized traffic, abandons and occasional resets
        for (int k = 0; k < 400; k++) begin
            tick();
            if (gnt_0) begin
                if ($urandom_range(1) == 1) addr_0 = 4'($urandom_range(15));
                else req_0 = 1'b0;
            end else if (req_0) begin
                if ($urandom_range(7) == 0) req_0 = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                req_0 = 1'b1; addr_0 = 4'($urandom_range(15));
            end
            if (gnt_1) begin
                if ($urandom_range(1) == 1) addr_1 = 4'($urandom_range(15));
                else req_1 = 1'b0;
            end else if (req_1) begin
                if ($urandom_range(7) == 0) req_1 = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                req_1 = 1'b1; addr_1 = 4'($urandom_range(15));
            end
            reset = ($urandom_range(63) == 0);
        end
        reset = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
